// File: rtl/instr_encoder.sv
// Packs simple MIPS-style instruction requests into 32-bit words and streams them into a 1024-word instruction memory.
// Optional feature: define INSTR_ENCODER_DELAY_SLOT_PAD_EN to follow every beq/jal/jr with a NOP delay-slot word.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [25:0] req_imm,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic [10:0] word_count,
  output logic        full,
  output logic        err
);

`ifdef INSTR_ENCODER_DELAY_SLOT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, PAD, FULL} state_t;

  state_t      state, state_nxt;
  logic [9:0]  ptr, ptr_nxt;
  logic        ready_q, ready_nxt;
  logic        we_nxt, full_nxt, err_nxt;
  logic [9:0]  addr_nxt;
  logic [31:0] wdata_nxt;
  logic [10:0] count_nxt;
  logic [31:0] enc;
  logic        legal, branch, accept;

  // A request arriving together with clear is never taken.
  assign req_ready = ready_q & ~clear;
  assign accept    = req_valid & ready_q & ~clear;

  always_comb begin
    enc    = '0;
    legal  = 1'b1;
    branch = 1'b0;
    case (req_op)
      4'd0: enc = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100001};
      4'd1: enc = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100011};
      4'd2: enc = {6'b001101, req_rs, req_rt, req_imm[15:0]};
      4'd3: enc = {6'b100011, req_rs, req_rt, req_imm[15:0]};
      4'd4: enc = {6'b101011, req_rs, req_rt, req_imm[15:0]};
      4'd5: begin
        enc    = {6'b000100, req_rs, req_rt, req_imm[15:0]};
        branch = 1'b1;
      end
      4'd6: begin
        enc    = {6'b000011, req_imm};
        branch = 1'b1;
      end
      4'd7: begin
        enc    = {6'b000000, req_rs, 15'b0, 6'b001000};
        branch = 1'b1;
      end
      4'd8: enc = {6'b001111, 5'b00000, req_rt, req_imm[15:0]};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ready_nxt = ready_q;
    we_nxt    = 1'b0;
    addr_nxt  = im_addr;
    wdata_nxt = im_wdata;
    count_nxt = word_count;
    full_nxt  = full;
    err_nxt   = err;
    if (clear) begin
      state_nxt = RUN;
      ptr_nxt   = '0;
      count_nxt = '0;
      full_nxt  = 1'b0;
      ready_nxt = 1'b1;
    end else begin
      case (state)
        RUN: begin
          ready_nxt = 1'b1;
          if (accept) begin
            if (!legal) begin
              err_nxt = 1'b1;
            end else begin
              we_nxt    = 1'b1;
              addr_nxt  = ptr;
              wdata_nxt = enc;
              ptr_nxt   = ptr + 10'd1;
              count_nxt = word_count + 11'd1;
              // The last slot wins over padding: no room remains for a NOP.
              if (ptr == 10'd1023) begin
                state_nxt = FULL;
                full_nxt  = 1'b1;
                ready_nxt = 1'b0;
              end else if (PAD_EN && branch) begin
                state_nxt = PAD;
                ready_nxt = 1'b0;
              end
            end
          end
        end
        PAD: begin
          we_nxt    = 1'b1;
          addr_nxt  = ptr;
          wdata_nxt = '0;
          ptr_nxt   = ptr + 10'd1;
          count_nxt = word_count + 11'd1;
          if (ptr == 10'd1023) begin
            state_nxt = FULL;
            full_nxt  = 1'b1;
            ready_nxt = 1'b0;
          end else begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end
        end
        FULL: ready_nxt = 1'b0;
        default: begin
          state_nxt = RUN;
          ready_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      ptr        <= '0;
      ready_q    <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      ready_q    <= ready_nxt;
      im_we      <= we_nxt;
      im_addr    <= addr_nxt;
      im_wdata   <= wdata_nxt;
      word_count <= count_nxt;
      full       <= full_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random requests against a cycle-level reference model.
// Honours INSTR_ENCODER_DELAY_SLOT_PAD_EN so the model matches whichever build is compiled.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_DELAY_SLOT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear, req_valid, req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [25:0] req_imm;
  logic        im_we, full, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;

  int m_ptr, m_count;
  bit m_full, m_pad, m_err, m_ready;
  bit e_we;
  int e_addr;
  logic [31:0] e_data;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .word_count(word_count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Field weights of the MIPS layout: opcode at 2^26, rs at 2^21, rt at 2^16, rd at 2^11.
  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int imm);
    longint unsigned p26 = 64'd67108864;
    longint unsigned i16 = longint'(imm % 65536);
    longint unsigned w;
    case (op)
      0: w = rs * 2097152 + rt * 65536 + rd * 2048 + 33;
      1: w = rs * 2097152 + rt * 65536 + rd * 2048 + 35;
      2: w = 13 * p26 + rs * 2097152 + rt * 65536 + i16;
      3: w = 35 * p26 + rs * 2097152 + rt * 65536 + i16;
      4: w = 43 * p26 + rs * 2097152 + rt * 65536 + i16;
      5: w = 4 * p26 + rs * 2097152 + rt * 65536 + i16;
      6: w = 3 * p26 + longint'(imm % 67108864);
      7: w = rs * 2097152 + 8;
      8: w = 15 * p26 + rt * 65536 + i16;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr = 0; m_count = 0; m_full = 0; m_pad = 0; m_err = 0; m_ready = 0;
    e_we = 0; e_addr = 0; e_data = '0;
  endtask

  task automatic modelWrite(logic [31:0] data);
    e_we = 1; e_addr = m_ptr; e_data = data;
    m_count++;
    m_ptr = (m_ptr + 1) % 1024;
  endtask

  task automatic modelStep(bit v, int op, int rs, int rt, int rd, int imm, bit clr);
    bit acc = v && m_ready && !clr;
    bit is_branch = (op == 5) || (op == 6) || (op == 7);
    e_we = 0;
    if (clr) begin
      m_ptr = 0; m_count = 0; m_full = 0; m_pad = 0; m_ready = 1;
    end else if (m_full) begin
      m_ready = 0;
    end else if (m_pad) begin
      m_pad = 0;
      modelWrite(32'h0);
      m_full  = (e_addr == 1023);
      m_ready = !m_full;
    end else if (acc && op > 8) begin
      m_err = 1;
    end else if (acc) begin
      modelWrite(ref_encode(op, rs, rt, rd, imm));
      if (e_addr == 1023) begin
        m_full = 1; m_ready = 0;
      end else if (PAD_EN && is_branch) begin
        m_pad = 1; m_ready = 0;
      end
    end else begin
      m_ready = 1;
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_we", im_we, 0);
    checkOutput("rst_addr", im_addr, 0);
    checkOutput("rst_wdata", im_wdata, 0);
    checkOutput("rst_count", word_count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ready", req_ready, 0);
  endtask

  // Called at a falling edge: drive, check handshake, advance one clock, check registered outputs.
  task automatic applyStimulus(bit v, int op, int rs, int rt, int rd, int imm, bit clr);
    req_valid = v; req_op = 4'(op); req_rs = 5'(rs); req_rt = 5'(rt);
    req_rd = 5'(rd); req_imm = 26'(imm); clear = clr;
    #1;
    checkOutput("req_ready", req_ready, (m_ready && !clr));
    modelStep(v, op, rs, rt, rd, imm, clr);
    @(posedge clk);
    @(negedge clk);
    checkOutput("im_we", im_we, e_we);
    if (e_we) begin
      checkOutput("im_addr", im_addr, e_addr);
      checkOutput("im_wdata", im_wdata, e_data);
    end
    checkOutput("word_count", word_count, m_count);
    checkOutput("full", full, m_full);
    checkOutput("err", err, m_err);
  endtask

  initial begin
    reset = 1; clear = 0; req_valid = 0; req_op = 0;
    req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0;
    modelReset();
    #12;
    checkReset();
    @(negedge clk);
    reset = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] addu encoding");
    applyStimulus(1, 0, 1, 2, 3, 0, 0);
    checkOutput("addu_word", im_wdata, 32'h00221821);
    checkOutput("addu_addr", im_addr, 0);
    checkOutput("addu_count", word_count, 1);

    $display("[TB] ori then lui back to back");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 2, 0, 1, 0, 32'h1234, 0);
    checkOutput("ori_word", im_wdata, 32'h34011234);
    applyStimulus(1, 8, 7, 1, 9, 32'hFFFF, 0);
    checkOutput("lui_word", im_wdata, 32'h3C01FFFF);
    checkOutput("lui_addr", im_addr, 1);

    $display("[TB] beq with optional delay slot");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 5, 1, 2, 0, 3, 0);
    checkOutput("beq_word", im_wdata, 32'h10220003);
    applyStimulus(1, 0, 4, 5, 6, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] illegal op");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 12, 3, 3, 3, 3, 0);
    checkOutput("illegal_err", err, 1);
    applyStimulus(1, 1, 9, 8, 7, 0, 0);
    checkOutput("after_illegal_addr", im_addr, 0);

    $display("[TB] fill with jal");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 1024; i++) applyStimulus(1, 6, 0, 0, 0, 32'hC03, 0);
`ifndef INSTR_ENCODER_DELAY_SLOT_PAD_EN
    checkOutput("last_jal_word", im_wdata, 32'h0C000C03);
    checkOutput("last_jal_addr", im_addr, 1023);
`endif
    applyStimulus(1, 6, 0, 0, 0, 32'hC03, 0);
    checkOutput("full_flag", full, 1);
    checkOutput("full_count", word_count, 1024);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("clear_full", full, 0);
    applyStimulus(1, 0, 1, 1, 1, 0, 0);
    checkOutput("after_clear_addr", im_addr, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 2, 3, 4, 0, 0);
    req_valid = 1; req_op = 4'd4; req_rs = 5'd1; req_rt = 5'd2; req_imm = 26'h55;
    #2 reset = 1;
    #1 checkReset();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    applyStimulus(1, 4, 1, 2, 0, 32'h55, 0);
    applyStimulus(1, 4, 1, 2, 0, 32'h55, 0);
    checkOutput("post_reset_addr", im_addr, 0);

    $display("[TB] random requests");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom % 67108864),
                    ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
